// File: rtl/lsu_ram_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ram_master
//  Purpose  : Initiator side of the 64-bit RAM port. Accepts a single
//             load/store from the LSU, issues one aligned RAM access with
//             lane-shifted write data and byte strobes, captures read data
//             the cycle after issue and returns sign/zero-extended results.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ram_master #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    // LSU request channel
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wen_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    // LSU response channel
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    // RAM controller side
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic [XLEN-1:0]   ram_rdata_i,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [XLEN-1:0]   ram_wdata_o,
    output logic [7:0]        ram_wstrb_o,
    output logic              ram_wen_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              store_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [XLEN-1:0]   ram_wdata_q;
    logic [7:0]        ram_wstrb_q;
    logic              ram_wen_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic              resp_err_q;

    logic [2:0]        align_mask_d;
    logic [7:0]        strb_base_d;
    logic              misaligned_d;
    logic [7:0]        wstrb_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   lane_d;
    logic [XLEN-1:0]   load_ext_d;

    // Request decode: alignment check, byte strobes and lane-shifted store data
    always_comb begin
        align_mask_d = 3'b000;
        strb_base_d  = 8'h01;
        case (req_size_i)
            2'd0: begin align_mask_d = 3'b000; strb_base_d = 8'h01; end
            2'd1: begin align_mask_d = 3'b001; strb_base_d = 8'h03; end
            2'd2: begin align_mask_d = 3'b011; strb_base_d = 8'h0F; end
            default: begin align_mask_d = 3'b111; strb_base_d = 8'hFF; end
        endcase
        misaligned_d = |(req_addr_i[2:0] & align_mask_d);
        wstrb_d      = strb_base_d << req_addr_i[2:0];
        wdata_d      = req_wdata_i << {req_addr_i[2:0], 3'b000};
    end

    // Load result: shift the addressed lane down, truncate and extend
    always_comb begin
        lane_d     = ram_rdata_i >> {off_q, 3'b000};
        load_ext_d = lane_d;
        case (size_q)
            2'd0: load_ext_d = uns_q ? {{(XLEN-8){1'b0}}, lane_d[7:0]}
                                     : {{(XLEN-8){lane_d[7]}}, lane_d[7:0]};
            2'd1: load_ext_d = uns_q ? {{(XLEN-16){1'b0}}, lane_d[15:0]}
                                     : {{(XLEN-16){lane_d[15]}}, lane_d[15:0]};
            2'd2: load_ext_d = uns_q ? {{(XLEN-32){1'b0}}, lane_d[31:0]}
                                     : {{(XLEN-32){lane_d[31]}}, lane_d[31:0]};
            default: load_ext_d = lane_d;
        endcase
    end

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            off_q        <= 3'b000;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            store_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wstrb_q  <= 8'h00;
            ram_wen_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        off_q       <= req_addr_i[2:0];
                        size_q      <= req_size_i;
                        uns_q       <= req_unsigned_i;
                        store_q     <= req_wen_i;
                        if (misaligned_d) begin
                            // No RAM access at all for a misaligned request
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= S_RESP;
                        end else begin
                            ram_addr_q <= {req_addr_i[ADDR_W-1:3], 3'b000};
                            if (req_wen_i) begin
                                ram_wen_q   <= 1'b1;
                                ram_wstrb_q <= wstrb_d;
                                ram_wdata_q <= wdata_d;
                            end
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // Write enable and strobes live for this one cycle only
                    ram_wen_q   <= 1'b0;
                    ram_wstrb_q <= 8'h00;
                    if (store_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_ext_d;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign ram_raddr_o  = ram_addr_q;
    assign ram_waddr_o  = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign ram_wstrb_o  = ram_wstrb_q;
    assign ram_wen_o    = ram_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ram_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ram_master
//  Purpose  : Self-checking bench for lsu_ram_master: vector table with a
//             response scoreboard, plus back-pressure and mid-access reset
//             sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ram_master;

    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wen_i;
    logic [63:0] req_addr_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] resp_rdata_o;
    logic        resp_err_o;
    logic [63:0] ram_raddr_o;
    logic [63:0] ram_rdata_i;
    logic [63:0] ram_waddr_o;
    logic [63:0] ram_wdata_o;
    logic [7:0]  ram_wstrb_o;
    logic        ram_wen_o;

    lsu_ram_master #(.XLEN(64), .ADDR_W(64)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_wen_i      (req_wen_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .ram_raddr_o    (ram_raddr_o),
        .ram_rdata_i    (ram_rdata_i),
        .ram_waddr_o    (ram_waddr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_wstrb_o    (ram_wstrb_o),
        .ram_wen_o      (ram_wen_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] rdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } resp_t;

    resp_t sbq[$];
    int    ntests = 0;
    int    nfail  = 0;
    int    wen_cnt = 0;

    // Count write-enable pulses, sampled mid-cycle
    always @(negedge clock_i) if (ram_wen_o === 1'b1) wen_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left #1 after a rising edge
    task automatic run_vec(input int idx, input vec_t v);
        int    lat;
        bit    done;
        int    wen0;
        resp_t e;
        resp_t got;
        string tag;
        tag = $sformatf("v%0d", idx);
        req_valid_i    = 1'b1;
        req_wen_i      = v.wen;
        req_addr_i     = v.addr;
        req_wdata_i    = v.wdata;
        req_size_i     = v.size;
        req_unsigned_i = v.uns;
        ram_rdata_i    = GARBAGE;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        e.lat   = v.exp_err ? 1 : (v.wen ? 2 : 3);
        sbq.push_back(e);
        wen0 = wen_cnt;
        @(posedge clock_i); #1;
        req_valid_i = 1'b0;
        chk({tag, " req_ready_busy"}, {63'd0, req_ready_o}, 64'd0);
        if (!v.exp_err) begin
            chk({tag, " ram_raddr"}, ram_raddr_o, v.exp_addr);
            chk({tag, " ram_waddr"}, ram_waddr_o, v.exp_addr);
            chk({tag, " ram_wen"}, {63'd0, ram_wen_o}, {63'd0, v.wen});
            chk({tag, " ram_wstrb"}, {56'd0, ram_wstrb_o}, {56'd0, v.wen ? v.exp_wstrb : 8'h00});
            if (v.wen) chk({tag, " ram_wdata"}, ram_wdata_o, v.exp_wdata);
        end
        lat  = 1;
        done = 1'b0;
        while (!done && lat < 10) begin
            if (resp_valid_o === 1'b1) begin
                done = 1'b1;
                got  = sbq.pop_front();
                chk({tag, " resp_err"}, {63'd0, resp_err_o}, {63'd0, got.err});
                chk({tag, " resp_rdata"}, resp_rdata_o, got.rdata);
                chk({tag, " latency"}, 64'(lat), 64'(got.lat));
            end else begin
                // RAM model: read data valid only in the cycle after issue
                ram_rdata_i = (lat == 2) ? v.rdata : GARBAGE;
                @(posedge clock_i); #1;
                lat++;
            end
        end
        ram_rdata_i = GARBAGE;
        if (!done) begin
            void'(sbq.pop_front());
            chk({tag, " resp_timeout"}, 64'd0, 64'd1);
        end
        @(posedge clock_i); #1;
        chk({tag, " resp_valid_drop"}, {63'd0, resp_valid_o}, 64'd0);
        chk({tag, " req_ready_back"}, {63'd0, req_ready_o}, 64'd1);
        chk({tag, " wen_pulses"}, 64'(wen_cnt - wen0), (v.wen && !v.exp_err) ? 64'd1 : 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        logic [63:0] held;
        int          wen0;

        // wen addr wdata size uns rdata | err exp_rdata exp_addr wstrb exp_wdata
        vecs[0]  = '{1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 64'h0,
                     1'b0, 64'h0, 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788};
        vecs[1]  = '{1'b1, 64'h8000_0003, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 64'h0,
                     1'b0, 64'h0, 64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000};
        vecs[2]  = '{1'b0, 64'h8000_0005, 64'h0, 2'd0, 1'b0, 64'h0000_8000_0000_0000,
                     1'b0, 64'hFFFF_FFFF_FFFF_FF80, 64'h8000_0000, 8'h00, 64'h0};
        vecs[3]  = '{1'b0, 64'h8000_0005, 64'h0, 2'd0, 1'b1, 64'h0000_8000_0000_0000,
                     1'b0, 64'h0000_0000_0000_0080, 64'h8000_0000, 8'h00, 64'h0};
        vecs[4]  = '{1'b0, 64'h8000_0000, 64'h0, 2'd3, 1'b0, 64'h0000_8000_0000_0000,
                     1'b0, 64'h0000_8000_0000_0000, 64'h8000_0000, 8'h00, 64'h0};
        vecs[5]  = '{1'b0, 64'h8000_0002, 64'h0, 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0,
                     1'b1, 64'h0, 64'h0, 8'h00, 64'h0};
        vecs[6]  = '{1'b1, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 64'h0,
                     1'b0, 64'h0, 64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000};
        vecs[7]  = '{1'b0, 64'h8000_0002, 64'h0, 2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0,
                     1'b0, 64'hFFFF_FFFF_FFFF_9ABC, 64'h8000_0000, 8'h00, 64'h0};
        vecs[8]  = '{1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0,
                     1'b0, 64'h0000_0000_1234_5678, 64'h8000_0000, 8'h00, 64'h0};
        vecs[9]  = '{1'b0, 64'h8000_0000, 64'h0, 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0,
                     1'b0, 64'hFFFF_FFFF_9ABC_DEF0, 64'h8000_0000, 8'h00, 64'h0};
        vecs[10] = '{1'b1, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 2'd2, 1'b0, 64'h0,
                     1'b0, 64'h0, 64'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000};
        vecs[11] = '{1'b1, 64'h8000_0004, 64'h1111_2222_3333_4444, 2'd3, 1'b0, 64'h0,
                     1'b1, 64'h0, 64'h0, 8'h00, 64'h0};
        vecs[12] = '{1'b0, 64'h8000_0006, 64'h0, 2'd1, 1'b1, 64'h8001_0000_0000_0000,
                     1'b0, 64'h0000_0000_0000_8001, 64'h8000_0000, 8'h00, 64'h0};
        vecs[13] = '{1'b1, 64'h8000_0001, 64'h0000_0000_0000_1234, 2'd1, 1'b0, 64'h0,
                     1'b1, 64'h0, 64'h0, 8'h00, 64'h0};

        reset_i        = 1'b1;
        req_valid_i    = 1'b0;
        req_wen_i      = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        resp_ready_i   = 1'b1;
        ram_rdata_i    = GARBAGE;

        // Reset state
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst resp_valid", {63'd0, resp_valid_o}, 64'd0);
        chk("rst resp_rdata", resp_rdata_o, 64'd0);
        chk("rst resp_err", {63'd0, resp_err_o}, 64'd0);
        chk("rst ram_wen", {63'd0, ram_wen_o}, 64'd0);
        chk("rst ram_wstrb", {56'd0, ram_wstrb_o}, 64'd0);
        chk("rst ram_waddr", ram_waddr_o, 64'd0);
        chk("rst ram_wdata", ram_wdata_o, 64'd0);
        @(negedge clock_i);
        reset_i = 1'b0;
        @(posedge clock_i); #1;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Back-pressure on a load response
        resp_ready_i   = 1'b0;
        req_valid_i    = 1'b1;
        req_wen_i      = 1'b0;
        req_addr_i     = 64'h8000_0018;
        req_size_i     = 2'd3;
        req_unsigned_i = 1'b0;
        @(posedge clock_i); #1;
        req_valid_i = 1'b0;
        @(posedge clock_i); #1;
        ram_rdata_i = 64'hA5A5_0102_0304_5A5A;
        @(posedge clock_i); #1;
        ram_rdata_i = GARBAGE;
        chk("bp resp_valid", {63'd0, resp_valid_o}, 64'd1);
        chk("bp resp_rdata", resp_rdata_o, 64'hA5A5_0102_0304_5A5A);
        held = resp_rdata_o;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock_i); #1;
            chk($sformatf("bp hold%0d valid", k), {63'd0, resp_valid_o}, 64'd1);
            chk($sformatf("bp hold%0d rdata", k), resp_rdata_o, 64'hA5A5_0102_0304_5A5A);
            chk($sformatf("bp hold%0d req_ready", k), {63'd0, req_ready_o}, 64'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clock_i); #1;
        chk("bp release valid", {63'd0, resp_valid_o}, 64'd0);
        chk("bp release req_ready", {63'd0, req_ready_o}, 64'd1);
        if (held !== 64'hA5A5_0102_0304_5A5A) chk("bp held", held, 64'hA5A5_0102_0304_5A5A);

        // Reset in the ACCESS cycle of a store
        wen0           = wen_cnt;
        req_valid_i    = 1'b1;
        req_wen_i      = 1'b1;
        req_addr_i     = 64'h8000_0020;
        req_wdata_i    = 64'h0102_0304_0506_0708;
        req_size_i     = 2'd3;
        @(posedge clock_i); #1;
        req_valid_i = 1'b0;
        chk("rstmid wen_before", {63'd0, ram_wen_o}, 64'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rstmid wen_dropped", {63'd0, ram_wen_o}, 64'd0);
        chk("rstmid resp_valid", {63'd0, resp_valid_o}, 64'd0);
        chk("rstmid req_ready", {63'd0, req_ready_o}, 64'd1);
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock_i); #1;
            chk($sformatf("rstmid noreplay%0d", k), {63'd0, resp_valid_o}, 64'd0);
        end
        chk("rstmid wen_pulses", 64'(wen_cnt - wen0), 64'd0);
        run_vec(99, '{1'b1, 64'h8000_0010, 64'h0000_0000_CAFE_F00D, 2'd2, 1'b0, 64'h0,
                      1'b0, 64'h0, 64'h8000_0010, 8'h0F, 64'h0000_0000_CAFE_F00D});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
